// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - RV32I memory-stage load/store unit
// Decodes width/alignment, drives the dmem handshake and extends load results.
module dmem_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        fault,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_read;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [2:0]  r_funct3;
  logic [1:0]  r_offset;
  logic        r_load_valid;
  logic [31:0] r_load_data;

  logic [1:0]  w_size;
  logic        w_f3_ok;
  logic        w_align_ok;
  logic        w_legal;
  logic        w_idle_req;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_lane_byte;
  logic [15:0] w_lane_half;
  logic [31:0] w_load_ext;

  // funct3[1:0] encodes log2 of the access size; 3 is never a valid width
  assign w_size = req_funct3[1:0];

  always_comb begin
    w_f3_ok = 1'b0;
    if (req_write) begin
      w_f3_ok = !req_funct3[2] && (w_size != 2'd3);
    end else begin
      w_f3_ok = (w_size != 2'd3) && !(req_funct3[2] && (w_size == 2'd2));
    end
  end

  always_comb begin
    w_align_ok = 1'b0;
    case (w_size)
      2'd0:    w_align_ok = 1'b1;
      2'd1:    w_align_ok = !req_addr[0];
      2'd2:    w_align_ok = (req_addr[1:0] == 2'b00);
      default: w_align_ok = 1'b0;
    endcase
  end

  assign w_legal    = w_f3_ok && w_align_ok;
  assign w_idle_req = (r_state == S_IDLE) && req_valid;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = req_wdata;
    case (w_size)
      2'd0: begin
        w_be    = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
      end
    endcase
  end

  always_comb begin
    w_lane_byte = dmem_rdata[7:0];
    case (r_offset)
      2'd0:    w_lane_byte = dmem_rdata[7:0];
      2'd1:    w_lane_byte = dmem_rdata[15:8];
      2'd2:    w_lane_byte = dmem_rdata[23:16];
      default: w_lane_byte = dmem_rdata[31:24];
    endcase
  end

  assign w_lane_half = r_offset[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    w_load_ext = dmem_rdata;
    case (r_funct3)
      3'd0:    w_load_ext = {{24{w_lane_byte[7]}}, w_lane_byte};
      3'd1:    w_load_ext = {{16{w_lane_half[15]}}, w_lane_half};
      3'd4:    w_load_ext = {24'd0, w_lane_byte};
      3'd5:    w_load_ext = {16'd0, w_lane_half};
      default: w_load_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_be         <= 4'd0;
      r_funct3     <= 3'd0;
      r_offset     <= 2'd0;
      r_load_valid <= 1'b0;
      r_load_data  <= 32'd0;
    end else begin
      r_load_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid && w_legal) begin
            r_state  <= S_BUSY;
            r_read   <= !req_write;
            r_write  <= req_write;
            r_addr   <= {req_addr[31:2], 2'b00};
            r_wdata  <= w_wdata;
            r_be     <= w_be;
            r_funct3 <= req_funct3;
            r_offset <= req_addr[1:0];
          end
        end
        S_BUSY: begin
          if (dmem_resp) begin
            r_state <= S_DONE;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            if (r_read) begin
              r_load_data  <= w_load_ext;
              r_load_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          // the instruction that just completed is still presented; never re-accept it
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall            = (w_idle_req && w_legal) || (r_state == S_BUSY);
  assign fault            = w_idle_req && !w_legal;
  assign load_valid       = r_load_valid;
  assign load_data        = r_load_data;
  assign dmem_read        = r_read;
  assign dmem_write       = r_write;
  assign dmem_addr        = r_addr;
  assign dmem_wdata       = r_wdata;
  assign dmem_byte_enable = r_be;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed and randomized checks of dmem_lsu
// Expected values come from an arithmetic model of RV32I load/store rules.
module tb_dmem_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic        fault;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_ld = 32'd0;

  dmem_lsu dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_write        (req_write),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .stall            (stall),
    .load_valid       (load_valid),
    .load_data        (load_data),
    .fault            (fault),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_rdata       (dmem_rdata),
    .dmem_resp        (dmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_legal(input bit w, input int f3, input logic [31:0] a);
    int sz;
    if (w && f3 > 2) return 1'b0;
    if (!w && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 1'b0;
    sz = 1 << (f3 % 4);
    return (a % sz) == 0;
  endfunction

  function automatic logic [3:0] m_be(input int f3, input logic [31:0] a);
    int sz;
    int mask;
    sz   = 1 << (f3 % 4);
    mask = ((1 << sz) - 1) << (a % 4);
    return mask[3:0];
  endfunction

  function automatic logic [31:0] m_store(input int f3, input logic [31:0] wd);
    if (f3 % 4 == 0) return (wd & 32'hFF) * 32'h01010101;
    if (f3 % 4 == 1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input int f3, input logic [31:0] a, input logic [31:0] rd);
    int sz;
    int bits;
    logic [31:0] val;
    logic [31:0] mask;
    sz   = 1 << (f3 % 4);
    bits = 8 * sz;
    val  = rd >> (8 * (a % 4));
    if (sz < 4) begin
      mask = (32'h1 << bits) - 32'h1;
      val  = val & mask;
      if (f3 < 4 && val[bits-1]) val = val | ~mask;
    end
    return val;
  endfunction

  // Leaves the bench in the IDLE cycle after completion, so a following call is back-to-back.
  task automatic do_access(input bit w, input int f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int k);
    bit legal;
    legal      = m_legal(w, f3, a);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3[2:0];
    req_addr   = a;
    req_wdata  = wd;
    #1;
    chk("accept_stall", {31'd0, stall}, {31'd0, legal});
    chk("accept_fault", {31'd0, fault}, {31'd0, !legal});
    chk("accept_noreq", {30'd0, dmem_read, dmem_write}, 32'd0);
    if (!legal) begin
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("fault_noreq", {30'd0, dmem_read, dmem_write}, 32'd0);
      chk("fault_pulse", {31'd0, fault}, 32'd0);
      chk("fault_nostall", {31'd0, stall}, 32'd0);
      return;
    end
    @(posedge clk); #1;
    for (int i = 1; i <= k; i++) begin
      chk("busy_read", {31'd0, dmem_read}, {31'd0, !w});
      chk("busy_write", {31'd0, dmem_write}, {31'd0, w});
      chk("busy_addr", dmem_addr, {a[31:2], 2'b00});
      chk("busy_be", {28'd0, dmem_byte_enable}, {28'd0, m_be(f3, a)});
      if (w) chk("busy_wdata", dmem_wdata, m_store(f3, wd));
      chk("busy_stall", {31'd0, stall}, 32'd1);
      chk("busy_lv", {31'd0, load_valid}, 32'd0);
      if (i == k) begin
        dmem_resp  = 1'b1;
        dmem_rdata = rd;
      end
      @(posedge clk); #1;
    end
    dmem_resp  = 1'b0;
    dmem_rdata = $urandom;
    if (!w) exp_ld = m_load(f3, a, rd);
    chk("done_noreq", {30'd0, dmem_read, dmem_write}, 32'd0);
    chk("done_stall", {31'd0, stall}, 32'd0);
    chk("done_fault", {31'd0, fault}, 32'd0);
    chk("done_lv", {31'd0, load_valid}, {31'd0, !w});
    chk("done_data", load_data, exp_ld);
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1;
    chk("idle_lv", {31'd0, load_valid}, 32'd0);
    chk("idle_stall", {31'd0, stall}, 32'd0);
    chk("idle_hold", load_data, exp_ld);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    dmem_rdata = 32'd0;
    dmem_resp  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {26'd0, stall, load_valid, fault, dmem_read, dmem_write, 1'b0}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_be", {28'd0, dmem_byte_enable}, 32'd0);
    chk("rst_ld", load_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_access(1'b0, 2, 32'h100, 32'h0, 32'hDEADBEEF, 3);
    chk("lw_value", exp_ld, 32'hDEADBEEF);
    do_access(1'b0, 0, 32'h103, 32'h0, 32'h80123456, 1);
    chk("lb_value", load_data, 32'hFFFFFF80);
    do_access(1'b0, 4, 32'h103, 32'h0, 32'h80123456, 2);
    chk("lbu_value", load_data, 32'h00000080);
    do_access(1'b0, 5, 32'h102, 32'h0, 32'h80010000, 1);
    chk("lhu_value", load_data, 32'h00008001);
    do_access(1'b1, 0, 32'h102, 32'h000000AB, 32'h0, 2);
    do_access(1'b1, 1, 32'h106, 32'h00001234, 32'h0, 1);
    do_access(1'b0, 1, 32'h101, 32'h0, 32'h0, 1);
    do_access(1'b1, 2, 32'h102, 32'h0, 32'h0, 1);
    do_access(1'b0, 3, 32'h100, 32'h0, 32'h0, 1);
    do_access(1'b0, 2, 32'h200, 32'h0, 32'h11223344, 1);
    do_access(1'b0, 1, 32'h202, 32'h0, 32'hF00D0000, 1);
    chk("b2b_lh", load_data, 32'hFFFFF00D);

    for (int n = 0; n < 60; n++) begin
      do_access(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
                $urandom, $urandom, int'($urandom_range(1, 4)));
    end

    // asynchronous reset while a load is outstanding
    do_access(1'b0, 2, 32'h300, 32'h0, 32'hCAFEF00D, 1);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'd2;
    req_addr   = 32'h400;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("pre_rst_read", {31'd0, dmem_read}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy_read", {31'd0, dmem_read}, 32'd0);
    chk("rst_busy_stall", {31'd0, stall}, 32'd0);
    chk("rst_busy_lv", {31'd0, load_valid}, 32'd0);
    chk("rst_busy_ld", load_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h12345678;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    chk("idle_resp_lv", {31'd0, load_valid}, 32'd0);
    chk("idle_resp_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    chk("idle_resp_lv2", {31'd0, load_valid}, 32'd0);
    chk("idle_resp_ld", load_data, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
